// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared Beta opcode constants, PCSEL encodings and predecode helper
package beta_pkg;

  localparam logic [5:0]  OP_LD    = 6'b011000;
  localparam logic [5:0]  OP_ST    = 6'b011001;
  localparam logic [5:0]  OP_LDR   = 6'b011111;
  localparam logic [31:0] BETA_NOP = 32'h83FF_F800;

  typedef enum logic [2:0] {
    PCSEL_INC   = 3'd0,
    PCSEL_BR    = 3'd1,
    PCSEL_JMP   = 3'd2,
    PCSEL_ILLOP = 3'd3,
    PCSEL_XADR  = 3'd4
  } pcsel_e;

  typedef struct packed {
    logic        ra2sel;
    logic        asel;
    logic        bsel;
    logic [31:0] sxtc;
  } predecode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic predecode_t beta_predecode(input logic [31:0] inst);
    predecode_t pd;
    logic [5:0] op;
    op        = inst[31:26];
    pd.ra2sel = (op == OP_ST);
    pd.asel   = (op == OP_LDR);
    pd.bsel   = (op[5:4] == 2'b11) || (op == OP_LD) || (op == OP_ST);
    pd.sxtc   = {{16{inst[15]}}, inst[15:0]};
    return pd;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO holding fetched {pc+4, instruction} entries
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < FULL) | do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; data needs no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - Beta fetch stage: PC, single-outstanding imem reads, queue, predecode
module instr_fetch_unit
  import beta_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h0000_0004,
  parameter logic [31:0] XADR_PC  = 32'h0000_0008,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [2:0]  pcsel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_ID,
  output logic        IF_RA2SEL,
  output logic        IF_ASEL,
  output logic        IF_BSEL,
  output logic [31:0] IF_SXTC
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   tag;
  logic          inflight;
  logic          kill;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  wentry;
  predecode_t    pd;

  // Decode the PCSEL redirect; 5..7 fall back to sequential fetch.
  always_comb begin
    redirect    = 1'b1;
    redirect_pc = fetch_pc;
    case (pcsel)
      PCSEL_BR:    redirect_pc = branch_target;
      PCSEL_JMP:   redirect_pc = {jmp_target[31:2], 2'b00};
      PCSEL_ILLOP: redirect_pc = ILLOP_PC;
      PCSEL_XADR:  redirect_pc = XADR_PC;
      default:     redirect    = 1'b0;
    endcase
  end

  assign imem_req  = rst_n & ~redirect & ~inflight & (count < QFULL);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_ready;
  assign resp      = imem_rvalid & inflight;
  // A response in a redirect cycle or one marked stale is dropped.
  assign push      = resp & ~kill & ~redirect;
  assign pop       = ~stall & (count != '0) & ~redirect;

  assign wentry.pc   = tag + 32'd4;
  assign wentry.inst = imem_rdata;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .head  (head),
    .count (count)
  );

  // Fetch PC, outstanding-read tracking and kill marker for a read orphaned by a redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      if (accept) begin
        inflight <= 1'b1;
        tag      <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp) begin
        inflight <= 1'b0;
        kill     <= 1'b0;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        if (inflight && !imem_rvalid) kill <= 1'b1;
      end
    end
  end

  assign if_valid  = (count != '0);
  assign IF_ID     = if_valid ? head.inst : BETA_NOP;
  assign IF_PC     = if_valid ? head.pc : 32'h0;
  assign pd        = beta_predecode(IF_ID);
  assign IF_RA2SEL = pd.ra2sel;
  assign IF_ASEL   = pd.asel;
  assign IF_BSEL   = pd.bsel;
  assign IF_SXTC   = pd.sxtc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import beta_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, imem_ready, imem_rvalid;
  logic [2:0]  pcsel;
  logic [31:0] branch_target, jmp_target, imem_rdata;
  logic        imem_req, if_valid, IF_RA2SEL, IF_ASEL, IF_BSEL;
  logic [31:0] imem_addr, IF_PC, IF_ID, IF_SXTC;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pcsel(pcsel),
    .branch_target(branch_target), .jmp_target(jmp_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .IF_PC(IF_PC), .IF_ID(IF_ID),
    .IF_RA2SEL(IF_RA2SEL), .IF_ASEL(IF_ASEL), .IF_BSEL(IF_BSEL), .IF_SXTC(IF_SXTC)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] sbq[$];
  logic [31:0] m_pc, m_tag;
  logic        m_inflight, m_live;
  int          mem_lat = 1;
  logic [1:0]  mv;
  logic [31:0] md [2];
  int          cyc = 0;
  logic        last_acc;
  logic [31:0] last_acc_addr;
  int          first_acc = -1;
  int          first_val = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h200: return 32'h6401_FFFC;
      32'h204: return 32'h7C00_0010;
      32'h208: return 32'h8000_0000;
      default: return a;
    endcase
  endfunction

  task automatic tick();
    logic        redir, want_req, resp;
    logic [31:0] tgt;
    @(negedge clk);
    redir = rst_n && (pcsel inside {[3'd1:3'd4]});
    case (pcsel)
      3'd1:    tgt = branch_target;
      3'd2:    tgt = {jmp_target[31:2], 2'b00};
      3'd3:    tgt = 32'h4;
      3'd4:    tgt = 32'h8;
      default: tgt = m_pc;
    endcase
    want_req = rst_n && !redir && !m_inflight && (sbq.size() < 2);
    chk("imem_req", imem_req, want_req);
    chk("if_valid", if_valid, sbq.size() > 0);
    if (if_valid && first_val < 0) first_val = cyc;
    if (sbq.size() > 0) begin
      chk("IF_PC", IF_PC, sbq[0][63:32]);
      chk("IF_ID", IF_ID, sbq[0][31:0]);
    end else begin
      chk("IF_PC_idle", IF_PC, 32'h0);
      chk("IF_ID_idle", IF_ID, BETA_NOP);
    end
    last_acc = want_req && imem_ready;
    if (last_acc) begin
      chk("imem_addr", imem_addr, m_pc);
      last_acc_addr = m_pc;
      if (first_acc < 0) first_acc = cyc;
    end
    resp = imem_rvalid && m_inflight;
    if (!rst_n) begin
      sbq.delete();
      m_inflight = 1'b0;
      m_live     = 1'b0;
      m_pc       = 32'h0;
    end else if (redir) begin
      sbq.delete();
      m_pc   = tgt;
      m_live = 1'b0;
      if (resp) m_inflight = 1'b0;
    end else begin
      if (!stall && sbq.size() > 0) void'(sbq.pop_front());
      if (resp) begin
        m_inflight = 1'b0;
        if (m_live) sbq.push_back({m_tag + 32'd4, mem_word(m_tag)});
      end
      if (last_acc) begin
        m_inflight = 1'b1;
        m_live     = 1'b1;
        m_tag      = m_pc;
        m_pc       = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    mv    = {1'b0, mv[1]};
    md[0] = md[1];
    if (last_acc) begin
      if (mem_lat == 1) begin mv[0] = 1'b1; md[0] = mem_word(last_acc_addr); end
      else              begin mv[1] = 1'b1; md[1] = mem_word(last_acc_addr); end
    end
    imem_rvalid = mv[0];
    imem_rdata  = mv[0] ? md[0] : 32'hDEAD_BEEF;
    cyc++;
  endtask

  task automatic wait_acc(input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk(tag, last_acc, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_valid) break;
    end
    chk(tag, if_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic [31:0] held;
    int          n;
    rst_n = 1'b0; stall = 1'b0; pcsel = 3'd0;
    branch_target = 32'h0; jmp_target = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mv = 2'b00; md[0] = 32'h0; md[1] = 32'h0;
    m_pc = 32'h0; m_tag = 32'h0; m_inflight = 1'b0; m_live = 1'b0;
    last_acc = 1'b0; last_acc_addr = 32'h0;

    // reset state
    tick(); tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_id", IF_ID, BETA_NOP);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_ra2sel", IF_RA2SEL, 1'b0);
    chk("rst_asel", IF_ASEL, 1'b0);
    chk("rst_bsel", IF_BSEL, 1'b0);
    chk("rst_sxtc", IF_SXTC, 32'hFFFF_F800);

    // sequential fetch
    rst_n = 1'b1; first_acc = -1; first_val = -1; n = 0;
    for (int i = 0; i < 14 && n < 3; i++) begin
      tick();
      if (last_acc) begin addrs[n] = last_acc_addr; n++; end
    end
    chk("seq_count", n, 3);
    chk("seq_addr0", addrs[0], 32'h0);
    chk("seq_addr1", addrs[1], 32'h4);
    chk("seq_addr2", addrs[2], 32'h8);
    chk("first_latency", first_val - first_acc, 2);

    // stall fills the queue
    stall = 1'b1;
    tick(); tick();
    held = IF_ID;
    chk("stall_valid", if_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold", IF_ID, held);
    end
    chk("stall_full_req", imem_req, 1'b0);
    stall = 1'b0;
    repeat (6) tick();

    // branch while a read is in flight
    mem_lat = 2;
    wait_acc("br_acc_seen");
    pcsel = 3'd1; branch_target = 32'h100;
    tick();
    pcsel = 3'd0;
    wait_acc("br_next_seen");
    chk("br_addr", last_acc_addr, 32'h100);
    wait_valid("br_valid_seen");
    chk("br_if_pc", IF_PC, 32'h104);

    // ILLOP redirect coinciding with rvalid
    mem_lat = 1;
    repeat (3) tick();
    wait_acc("ill_acc_seen");
    pcsel = 3'd3;
    tick();
    pcsel = 3'd0;
    wait_acc("ill_next_seen");
    chk("ill_addr", last_acc_addr, 32'h4);
    wait_valid("ill_valid_seen");
    chk("ill_if_pc", IF_PC, 32'h8);
    chk("ill_if_id", IF_ID, 32'h4);

    // predecode of ST / LDR / ADD
    stall = 1'b1;
    pcsel = 3'd2; jmp_target = 32'h203;
    tick();
    pcsel = 3'd0;
    repeat (8) tick();
    chk("st_id", IF_ID, 32'h6401_FFFC);
    chk("st_ra2sel", IF_RA2SEL, 1'b1);
    chk("st_asel", IF_ASEL, 1'b0);
    chk("st_bsel", IF_BSEL, 1'b1);
    chk("st_sxtc", IF_SXTC, 32'hFFFF_FFFC);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    chk("ldr_id", IF_ID, 32'h7C00_0010);
    chk("ldr_asel", IF_ASEL, 1'b1);
    chk("ldr_ra2sel", IF_RA2SEL, 1'b0);
    chk("ldr_bsel", IF_BSEL, 1'b0);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    repeat (4) tick();
    chk("add_id", IF_ID, 32'h8000_0000);
    chk("add_ra2sel", IF_RA2SEL, 1'b0);
    chk("add_asel", IF_ASEL, 1'b0);
    chk("add_bsel", IF_BSEL, 1'b0);
    chk("add_sxtc", IF_SXTC, 32'h0);
    stall = 1'b0;

    // PC wrap
    pcsel = 3'd2; jmp_target = 32'hFFFF_FFFC;
    tick();
    pcsel = 3'd0;
    wait_acc("wrap_acc_seen");
    chk("wrap_addr_hi", last_acc_addr, 32'hFFFF_FFFC);
    wait_acc("wrap_next_seen");
    chk("wrap_addr_lo", last_acc_addr, 32'h0);
    repeat (4) tick();

    // reset with a read outstanding, late rvalid afterwards
    mem_lat = 2;
    wait_acc("rst_acc_seen");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", if_valid, 1'b0);
    tick();
    chk("late_rvalid_valid", if_valid, 1'b0);
    chk("post_rst_addr", last_acc_addr, 32'h0);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
